// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned MAX_BURST_DEF    = 8;
  localparam int unsigned IDLE_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W            = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // (base + offset) mod n for base < n and offset <= n; single explicit wrap
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    int unsigned t;
    t = base + offset;
    if (t >= n) t = t - n;
    return t;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority pick: first set valid bit after rr_last, wrapping modulo N_REQ.
module fifo_wr_arbiter_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_last,
  output logic [IDX_W-1:0] winner_c,
  output logic             any_c
);

  int unsigned           idx;
  logic [IDX_W-1:0]      sel;

  // Scan from the farthest offset down so the nearest one after rr_last wins
  always_comb begin
    winner_c = '0;
    any_c    = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = rr_index(32'(rr_last), 32'(k), N_REQ);
      sel = IDX_W'(idx);
      if (valid[sel]) begin
        winner_c = sel;
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned len_data     = DATA_W_DEF,
  parameter int unsigned MAX_BURST    = MAX_BURST_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*len_data-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [len_data-1:0]       fifo_data,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_id,
  output logic [7:0]                dbg_beats
);

  logic [0:0]       state_q, state_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] idle_q, idle_d;

  logic [IDX_W-1:0] pick_id_c;
  logic             pick_any_c;
  logic             owner_valid_c;
  logic             owner_last_c;
  logic             transfer_c;
  logic             release_c;
  logic [CNT_W-1:0] beats_inc_c;
  logic [CNT_W-1:0] idle_inc_c;

  fifo_wr_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid    (req_valid),
    .rr_last  (rr_last_q),
    .winner_c (pick_id_c),
    .any_c    (pick_any_c)
  );

  assign owner_valid_c = req_valid[grant_id_q];
  assign owner_last_c  = req_last[grant_id_q];
  assign transfer_c    = (state_q == ST_BURST) && owner_valid_c && !fifo_full;
  assign beats_inc_c   = beats_q + 8'd1;
  assign idle_inc_c    = idle_q + 8'd1;

  // Next-state: grant in IDLE, count beats / idle cycles in BURST
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_last_d     = rr_last_q;
    beats_d       = beats_q;
    idle_d        = idle_q;
    release_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          state_d       = ST_BURST;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_id_c;
          beats_d       = '0;
          idle_d        = '0;
        end
      end
      ST_BURST: begin
        if (transfer_c) begin
          beats_d = beats_inc_c;
          idle_d  = '0;
          if (owner_last_c || (beats_inc_c == CNT_W'(MAX_BURST))) release_c = 1'b1;
        end else if (!owner_valid_c) begin
          // A full-stall with valid high is not idle time
          idle_d = idle_inc_c;
          if (idle_inc_c == CNT_W'(IDLE_TIMEOUT)) release_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (release_c) begin
      state_d       = ST_IDLE;
      grant_valid_d = 1'b0;
      rr_last_d     = grant_id_q;
      beats_d       = '0;
      idle_d        = '0;
    end
  end

  // Port-side handshake and data steering follow the current owner combinationally
  always_comb begin
    req_ready  = '0;
    fifo_write = transfer_c;
    fifo_data  = '0;
    if (state_q == ST_BURST) req_ready[grant_id_q] = !fifo_full;
    if (grant_valid_q) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (grant_id_q == IDX_W'(i)) fifo_data = req_data[i*len_data +: len_data];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_last_q     <= IDX_W'(N_REQ - 1);
      beats_q       <= '0;
      idle_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_last_q     <= rr_last_d;
      beats_q       <= beats_d;
      idle_q        <= idle_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign dbg_beats   = beats_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: behavioural arbiter model compared every cycle, plus directed literal checks.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_write;
  logic [DW-1:0]  fifo_data;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [7:0]     dbg_beats;

  fifo_wr_arbiter #(.N_REQ(NR), .len_data(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .grant_valid(grant_valid),
    .grant_id(grant_id), .dbg_beats(dbg_beats)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: who owns the port (-1 = nobody), last granted, last released, burst counters
  int m_owner, m_gid, m_rr, m_beats, m_idle;

  logic [31:0] wq[$];   // written data
  logic [31:0] oq[$];   // owner per write
  logic [31:0] gq[$];   // grant ids at grant start
  logic [31:0] gc[$];   // cycle of grant start
  logic        prev_gv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [NR*DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1; asserts reset asynchronously and holds it two edges
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_write", 32'(fifo_write), 32'h0);
    chk("rst_data", fifo_data, 32'h0);
    chk("rst_gvalid", 32'(grant_valid), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_beats", 32'(dbg_beats), 32'h0);
    m_owner = -1; m_gid = 0; m_rr = NR - 1; m_beats = 0; m_idle = 0;
    prev_gv = 1'b0; cyc = 0;
    wq.delete(); oq.delete(); gq.delete(); gc.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                      input logic [NR*DW-1:0] d, input logic f);
    logic [NR-1:0] e_ready;
    logic          e_write;
    logic [31:0]   e_data;
    bit            rel;
    req_valid = v; req_last = l; req_data = d; fifo_full = f;
    #3;
    e_ready = '0; e_write = 1'b0; e_data = '0;
    if (m_owner >= 0) begin
      e_ready[m_owner] = !f;
      e_write = v[m_owner] && !f;
      e_data = d[m_owner*DW +: DW];
    end
    chk("ready", 32'(req_ready), 32'(e_ready));
    chk("write", 32'(fifo_write), 32'(e_write));
    chk("data", fifo_data, e_data);
    chk("gvalid", 32'(grant_valid), 32'(m_owner >= 0));
    chk("gid", 32'(grant_id), 32'(m_gid));
    chk("beats", 32'(dbg_beats), 32'(m_beats));
    if (fifo_write) begin wq.push_back(fifo_data); oq.push_back(32'(grant_id)); end
    if (grant_valid && !prev_gv) begin gq.push_back(32'(grant_id)); gc.push_back(32'(cyc)); end
    prev_gv = grant_valid;
    rel = 0;
    if (m_owner < 0) begin
      for (int k = NR; k >= 1; k--)
        if (v[(m_rr + k) % NR]) m_owner = (m_rr + k) % NR;
      if (m_owner >= 0) begin m_gid = m_owner; m_beats = 0; m_idle = 0; end
    end else if (e_write) begin
      m_beats++; m_idle = 0;
      rel = l[m_owner] || (m_beats == MB);
    end else if (!v[m_owner]) begin
      m_idle++;
      rel = (m_idle == TO);
    end
    if (rel) begin m_rr = m_owner; m_owner = -1; m_beats = 0; m_idle = 0; end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int n;
    logic [NR*DW-1:0] d;
    logic [NR-1:0] v, l;
    int thr;
    #1;
    do_reset();

    // Valid on 1 and 3: first burst to 1 for MAX_BURST beats, bubble, then 3
    for (int i = 0; i < 14; i++) step(4'b1010, 4'b0000, rnd_data(), 1'b0);
    n = 0;
    while (n < oq.size() && oq[n] == 1) n++;
    chk("a_burst_len", 32'(n), 32'd8);
    chk("a_next_owner", qat(oq, 8), 32'd3);
    chk("a_grant0", qat(gq, 0), 32'd1);
    chk("a_grant0_cyc", qat(gc, 0), 32'd1);
    chk("a_grant1", qat(gq, 1), 32'd3);
    chk("a_grant1_cyc", qat(gc, 1), 32'd10);

    // Three-beat packet from 0 with a five-cycle full stall on beat 2
    do_reset();
    for (int i = 0; i < 11; i++) begin
      d = rnd_data();
      d[31:0] = (i <= 1) ? 32'hA0 : (i <= 7) ? 32'hA1 : 32'hA2;
      step((i <= 8) ? 4'b0001 : 4'b0000, (i == 8) ? 4'b0001 : 4'b0000, d,
           (i >= 2 && i <= 6));
    end
    chk("b_nwrites", 32'(wq.size()), 32'd3);
    chk("b_w0", qat(wq, 0), 32'hA0);
    chk("b_w1", qat(wq, 1), 32'hA1);
    chk("b_w2", qat(wq, 2), 32'hA2);
    chk("b_released", 32'(grant_valid), 32'd0);

    // Owner 0 goes quiet after 2 beats while 1 and 2 wait: timeout then grant 1
    do_reset();
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step((i < 3) ? 4'b0001 : 4'b0110, 4'b0000, rnd_data(), 1'b0);
      if (i >= 3 && prev_gv && qat(gq, 0) == 0 && gq.size() == 1) n++;
    end
    chk("c_idle_cycles", 32'(n), 32'd16);
    chk("c_next_grant", qat(gq, 1), 32'd1);

    // All requesting: order 0,1,2,3,0 at 9 cycles per burst
    do_reset();
    for (int i = 0; i < 40; i++) step(4'b1111, 4'b0000, rnd_data(), 1'b0);
    for (int i = 0; i < 5; i++) chk("d_order", qat(gq, i), 32'(i % NR));
    chk("d_period", qat(gc, 1) - qat(gc, 0), 32'd9);
    chk("d_period2", qat(gc, 4) - qat(gc, 3), 32'd9);

    // Reset during owner 1's fourth beat; requester 0 must win afterwards
    do_reset();
    for (int i = 0; i < 14; i++) step(4'b1111, 4'b0000, rnd_data(), 1'b0);
    chk("e_mid_beats", 32'(dbg_beats), 32'd4);
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, rnd_data(), 1'b0);
    chk("e_after_rst", qat(gq, 0), 32'd0);

    // Randomised traffic, alternating busy and sparse valid to reach timeouts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      thr = ((i / 200) % 2 == 1) ? 1 : 9;
      for (int b = 0; b < NR; b++) v[b] = ($urandom_range(0, 15) < thr);
      l = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(v, l, rnd_data(), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (32-bit data, depth 16, i_write/i_data/o_full) among N producers.
- Round-robin arbitration, one owner at a time; owner holds the port for a burst ending on last, beat cap, or idle timeout.
- Sits directly in front of the FIFO; arbiter outputs drive FIFO i_write/i_data, FIFO o_full feeds back.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- len_data, 32, data width; must match the FIFO
- MAX_BURST, 8, maximum beats per grant (1..255)
- IDLE_TIMEOUT, 16, consecutive cycles with owner valid low before forced release (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_last  in  N_REQ  per-requester end-of-packet; qualified by valid
- req_data  in  N_REQ*len_data  requester i data at bits [i*len_data +: len_data]
- req_ready  out  N_REQ  per-requester accept
- fifo_full  in  1  FIFO o_full
- fifo_write  out  1  FIFO i_write
- fifo_data  out  len_data  FIFO i_data
- grant_valid  out  1  a requester owns the port
- grant_id  out  $clog2(N_REQ)  current owner index
- dbg_beats  out  8  beats accepted in current burst

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=0; fifo_write=0; fifo_data=0; grant_valid=0; grant_id=0; dbg_beats=0; rr_last=N_REQ-1, so requester 0 has top priority after reset. Reset mid-burst drops the burst immediately; nothing is written in reset cycles.
- States: IDLE, BURST.
- IDLE: all req_ready=0, fifo_write=0. If any req_valid, select first asserted index searching rr_last+1, rr_last+2, ... modulo N_REQ. Next edge: grant_id<=winner, grant_valid<=1, beat count<=0, idle count<=0, state<=BURST. No valid: stay IDLE.
- Arbitration latency: 1 cycle from req_valid high in IDLE to req_ready possible.
- BURST: req_ready[grant_id]=!fifo_full (combinational); all other ready=0.
  - Transfer = req_valid[grant_id] && req_ready[grant_id].
  - fifo_write=transfer; fifo_data=req_data slice of grant_id when grant_valid, else 0.
  - fifo_write is never asserted while fifo_full=1.
- On each transfer: beats+1; idle count<=0.
- Release conditions, evaluated on the transfer edge:
  - req_last[grant_id] set on the transfer; or
  - beats+1 == MAX_BURST.
  - On release: state<=IDLE, grant_valid<=0, rr_last<=grant_id, beats<=0.
- Idle timeout: a cycle with req_valid[grant_id]=0 increments idle count; reaching IDLE_TIMEOUT releases the same way.
  - Cycles stalled by fifo_full while valid=1 do not count toward the timeout and never release.
- Back-to-back: every release passes through one IDLE cycle (one bubble); no grant in the release cycle.
- Fairness: a requester with valid held is granted within N_REQ-1 other bursts.
- Non-owner valid/last/data ignored. Owner must hold data stable while valid and !ready; arbiter does not check this.
- dbg_beats = beat counter, 8-bit, saturates impossible (capped by MAX_BURST).
- Widths: counters 8-bit unsigned; rr index modulo N_REQ with explicit wrap, no reliance on power-of-2 N_REQ.

Decomposition:
- Shared package fifo_arb_pkg: state enum (IDLE, BURST), default constants (N_REQ, MAX_BURST, IDLE_TIMEOUT), function for rotating-priority index.
- One sub-module natural: rr_pick (combinational rotate-first-one-select, inputs valid vector and rr_last, outputs winner and any).
- Top instantiates rr_pick plus FSM/counters/data mux.

Test Plan:
- Reset then req_valid=4'b1010, no last, FIFO empty -> grant_id=1 one cycle after valid; 8 writes; release; IDLE bubble; grant_id=3.
- Req 0 sends 3 beats 0xA0,0xA1,0xA2 with last on third -> exactly 3 fifo_write pulses with those values; grant released after 0xA2; dbg_beats 1,2,3 then 0.
- fifo_full=1 during beat 2 for 5 cycles -> req_ready[owner]=0 and fifo_write=0 for those 5 cycles; no timeout release; beat 2 written the cycle after full drops.
- Owner valid drops after 2 beats, others valid -> release exactly 16 cycles later; next grant to the following index.
- All 4 valid continuously, MAX_BURST=8 -> grant order 0,1,2,3,0; each 8 beats; one bubble between bursts; 9 cycles per burst.
- rst_n low for 2 cycles mid-burst (beat 4) -> outputs zero immediately (async); after release, requester 0 granted first regardless of prior owner.
